// File: rtl/hazard_ctrl_pkg.sv
// Shared widths and hazard-cause encoding for the hazard controller and the
// trace/debug logic that observes it.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned MD_CNT_W = 8;

  typedef enum logic [2:0] {
    HZ_NONE   = 3'd0,
    HZ_FREEZE = 3'd1,
    HZ_FLUSH  = 3'd2,
    HZ_LU     = 3'd3,
    HZ_MD     = 3'd4
  } hz_cause_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // Highest-priority cause wins; a wrong-path ID instruction never stalls.
  function automatic hz_cause_e hz_resolve(input logic freeze,
                                           input logic flush,
                                           input logic lu,
                                           input logic md);
    hz_cause_e c;
    if (freeze)     c = HZ_FREEZE;
    else if (flush) c = HZ_FLUSH;
    else if (lu)    c = HZ_LU;
    else if (md)    c = HZ_MD;
    else            c = HZ_NONE;
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Wrapping event counter with enable and asynchronous active-high reset.
module hazard_perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX-resolved flushes, MUL/DIV
// HI/LO interlock and data-memory freeze, plus stall/flush/freeze counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_usesRt,
  input  logic             ID_isMulDiv,
  input  logic             ID_readsHiLo,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_rt,
  input  logic             EX_taken,
  input  logic             mem_busy,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_sel,
  output logic             ID_EX_hold,
  output logic             EX_MEM_hold,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LATENCY);

  md_state_e           state_q, state_d;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;

  logic      lu_hazard;
  logic      md_hazard;
  logic      issue;
  hz_cause_e cause;

  assign md_busy   = (md_cnt_q != '0);
  assign lu_hazard = EX_MemRead && (EX_rt != '0) &&
                     ((EX_rt == ID_rs) || (ID_usesRt && (EX_rt == ID_rt)));
  assign md_hazard = md_busy && (ID_readsHiLo || ID_isMulDiv);
  assign cause     = hz_resolve(mem_busy, EX_taken, lu_hazard, md_hazard);
  assign issue     = !rst && (cause == HZ_NONE);

  always_comb begin
    PC_write    = 1'b0;
    IF_ID_write = 1'b0;
    IF_ID_flush = 1'b0;
    ID_EX_sel   = 1'b0;
    ID_EX_hold  = 1'b0;
    EX_MEM_hold = 1'b0;
    if (rst) begin
      ID_EX_sel = 1'b1;
    end else begin
      unique case (cause)
        HZ_FREEZE: begin
          ID_EX_hold  = 1'b1;
          EX_MEM_hold = 1'b1;
        end
        HZ_FLUSH: begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
          IF_ID_flush = 1'b1;
          ID_EX_sel   = 1'b1;
        end
        HZ_LU, HZ_MD: begin
          ID_EX_sel = 1'b1;
        end
        default: begin
          PC_write    = 1'b1;
          IF_ID_write = 1'b1;
        end
      endcase
    end
  end

  // The countdown runs through freeze cycles so HI/LO timing tracks real time.
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      MD_IDLE: begin
        if (issue && ID_isMulDiv) begin
          md_cnt_d = MD_LOAD;
          state_d  = MD_BUSY;
        end
      end
      MD_BUSY: begin
        md_cnt_d = md_cnt_q - 1'b1;
        if (md_cnt_q <= MD_CNT_W'(1)) begin
          md_cnt_d = '0;
          state_d  = MD_IDLE;
        end
      end
      default: begin
        md_cnt_d = '0;
        state_d  = MD_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  logic stall_en, flush_en, freeze_en;

  assign freeze_en = (cause == HZ_FREEZE);
  assign flush_en  = (cause == HZ_FLUSH);
  assign stall_en  = (cause == HZ_LU) || (cause == HZ_MD);

  hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (stall_en),
    .cnt_o (stall_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (flush_en),
    .cnt_o (flush_cnt)
  );

  hazard_perf_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (freeze_en),
    .cnt_o (freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int LAT = 4;
  localparam int CW  = 4;

  localparam int M_RUN    = 0;
  localparam int M_FREEZE = 1;
  localparam int M_FLUSH  = 2;
  localparam int M_STALL  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    ID_rs, ID_rt, EX_rt;
  logic          ID_usesRt, ID_isMulDiv, ID_readsHiLo, EX_MemRead, EX_taken, mem_busy;
  logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_sel, ID_EX_hold, EX_MEM_hold, md_busy;
  logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;
  logic [6:0]    ctrl;

  int tests_run = 0;
  int tests_failed = 0;

  // Model state
  int m_md = 0;
  int m_stall = 0, m_flush = 0, m_freeze = 0;

  always #5 clk = ~clk;

  assign ctrl = {PC_write, IF_ID_write, IF_ID_flush, ID_EX_sel, ID_EX_hold, EX_MEM_hold, md_busy};

  hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ID_rs        (ID_rs),
    .ID_rt        (ID_rt),
    .ID_usesRt    (ID_usesRt),
    .ID_isMulDiv  (ID_isMulDiv),
    .ID_readsHiLo (ID_readsHiLo),
    .EX_MemRead   (EX_MemRead),
    .EX_rt        (EX_rt),
    .EX_taken     (EX_taken),
    .mem_busy     (mem_busy),
    .PC_write     (PC_write),
    .IF_ID_write  (IF_ID_write),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_sel    (ID_EX_sel),
    .ID_EX_hold   (ID_EX_hold),
    .EX_MEM_hold  (EX_MEM_hold),
    .md_busy      (md_busy),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .freeze_cnt   (freeze_cnt)
  );

  function automatic int model_mode();
    bit lu, mdh;
    lu  = EX_MemRead && (EX_rt != 0) && (EX_rt == ID_rs || (ID_usesRt && EX_rt == ID_rt));
    mdh = (m_md != 0) && (ID_readsHiLo || ID_isMulDiv);
    if (mem_busy)       return M_FREEZE;
    if (EX_taken)       return M_FLUSH;
    if (lu || mdh)      return M_STALL;
    return M_RUN;
  endfunction

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_sel, ID_EX_hold, EX_MEM_hold, md_busy}
  function automatic logic [6:0] exp_ctrl(input int mode, input bit mdb);
    logic [6:0] v;
    case (mode)
      M_FREEZE: v = 7'b0000110;
      M_FLUSH:  v = 7'b1111000;
      M_STALL:  v = 7'b0001000;
      default:  v = 7'b1100000;
    endcase
    v[0] = mdb;
    return v;
  endfunction

  function automatic logic [3*CW-1:0] exp_cnts();
    return {CW'(m_stall % 16), CW'(m_flush % 16), CW'(m_freeze % 16)};
  endfunction

  task automatic set_idle();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
    ID_usesRt = 1'b0; ID_isMulDiv = 1'b0; ID_readsHiLo = 1'b0;
    EX_MemRead = 1'b0; EX_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic model_clear();
    m_md = 0; m_stall = 0; m_flush = 0; m_freeze = 0;
  endtask

  // One clock: advance the model with the inputs seen at the edge.
  task automatic clk_cycle();
    int mode;
    mode = model_mode();
    @(posedge clk);
    case (mode)
      M_FREEZE: m_freeze++;
      M_FLUSH:  m_flush++;
      M_STALL:  m_stall++;
      default:  ;
    endcase
    if (m_md > 0) m_md--;
    else if (mode == M_RUN && ID_isMulDiv) m_md = LAT;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_idle();
    #2;
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (ctrl !== 7'b0001000) begin
      tests_failed++;
      $display("FAIL reset_ctrl got %b expected %b", ctrl, 7'b0001000);
    end
    tests_run++;
    if ({stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_cnts got %h expected 0", {stall_cnt, flush_cnt, freeze_cnt});
    end
    rst = 1'b0;
    model_clear();
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL reset_release_run got %b expected %b", ctrl, 7'b1100000);
    end
    clk_cycle();
  endtask

  task automatic test_load_use();
    set_idle();
    EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5;
    #1;
    tests_run++;
    if (ctrl !== 7'b0001000) begin
      tests_failed++;
      $display("FAIL lu_stall got %b expected %b", ctrl, 7'b0001000);
    end
    clk_cycle();
    set_idle();
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000 || stall_cnt !== CW'(1)) begin
      tests_failed++;
      $display("FAIL lu_after got ctrl=%b stall=%0d expected ctrl=1100000 stall=1", ctrl, stall_cnt);
    end
    clk_cycle();
    // rt-side match counts only when the instruction reads rt
    EX_MemRead = 1'b1; EX_rt = 5'd7; ID_rt = 5'd7; ID_rs = 5'd1; ID_usesRt = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== 7'b0001000) begin
      tests_failed++;
      $display("FAIL lu_rt got %b expected %b", ctrl, 7'b0001000);
    end
    clk_cycle();
    ID_usesRt = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL lu_rt_unused got %b expected %b", ctrl, 7'b1100000);
    end
    clk_cycle();
    EX_rt = 5'd0; ID_rs = 5'd0;
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL lu_r0 got %b expected %b", ctrl, 7'b1100000);
    end
    clk_cycle();
    set_idle();
    #1;
    tests_run++;
    if (stall_cnt !== CW'(2)) begin
      tests_failed++;
      $display("FAIL lu_count got %0d expected 2", stall_cnt);
    end
  endtask

  task automatic test_mul_interlock();
    int s0;
    s0 = m_stall;
    set_idle();
    ID_isMulDiv = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL mul_issue got %b expected %b", ctrl, 7'b1100000);
    end
    clk_cycle();
    ID_isMulDiv = 1'b0; ID_readsHiLo = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      #1;
      tests_run++;
      if (ctrl !== 7'b0001001) begin
        tests_failed++;
        $display("FAIL mfhi_stall[%0d] got %b expected %b", i, ctrl, 7'b0001001);
      end
      clk_cycle();
    end
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL mfhi_issue got %b expected %b", ctrl, 7'b1100000);
    end
    clk_cycle();
    set_idle();
    tests_run++;
    if (stall_cnt !== CW'((s0 + LAT) % 16)) begin
      tests_failed++;
      $display("FAIL mul_stall_count got %0d expected %0d", stall_cnt, (s0 + LAT) % 16);
    end
  endtask

  task automatic test_flush_beats_stall();
    int s0, f0;
    s0 = m_stall; f0 = m_flush;
    set_idle();
    EX_MemRead = 1'b1; EX_rt = 5'd5; ID_rs = 5'd5; EX_taken = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== 7'b1111000) begin
      tests_failed++;
      $display("FAIL flush_ctrl got %b expected %b", ctrl, 7'b1111000);
    end
    clk_cycle();
    set_idle();
    #1;
    tests_run++;
    if (flush_cnt !== CW'((f0 + 1) % 16) || stall_cnt !== CW'(s0 % 16)) begin
      tests_failed++;
      $display("FAIL flush_counts got flush=%0d stall=%0d expected flush=%0d stall=%0d",
               flush_cnt, stall_cnt, (f0 + 1) % 16, s0 % 16);
    end
  endtask

  task automatic test_freeze();
    int z0, f0;
    set_idle();
    ID_isMulDiv = 1'b1;
    clk_cycle();
    z0 = m_freeze; f0 = m_flush;
    set_idle();
    mem_busy = 1'b1; EX_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (ctrl !== 7'b0000111) begin
        tests_failed++;
        $display("FAIL freeze[%0d] got %b expected %b", i, ctrl, 7'b0000111);
      end
      clk_cycle();
    end
    mem_busy = 1'b0;
    #1;
    tests_run++;
    if (ctrl !== 7'b1111001) begin
      tests_failed++;
      $display("FAIL freeze_then_flush got %b expected %b", ctrl, 7'b1111001);
    end
    clk_cycle();
    set_idle();
    #1;
    tests_run++;
    if (md_busy !== 1'b0 || freeze_cnt !== CW'((z0 + 3) % 16) || flush_cnt !== CW'((f0 + 1) % 16)) begin
      tests_failed++;
      $display("FAIL freeze_after got md_busy=%b freeze=%0d flush=%0d expected md_busy=0 freeze=%0d flush=%0d",
               md_busy, freeze_cnt, flush_cnt, (z0 + 3) % 16, (f0 + 1) % 16);
    end
  endtask

  task automatic test_reset_mid_md();
    set_idle();
    ID_isMulDiv = 1'b1;
    clk_cycle();
    set_idle();
    clk_cycle();
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== 7'b0001000 || {stall_cnt, flush_cnt, freeze_cnt} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_md got ctrl=%b cnts=%h expected ctrl=0001000 cnts=0",
               ctrl, {stall_cnt, flush_cnt, freeze_cnt});
    end
    rst = 1'b0;
    model_clear();
    ID_readsHiLo = 1'b1;
    #1;
    tests_run++;
    if (ctrl !== 7'b1100000) begin
      tests_failed++;
      $display("FAIL reset_mid_md_release got %b expected %b", ctrl, 7'b1100000);
    end
    clk_cycle();
  endtask

  task automatic test_counter_wrap();
    do_reset();
    EX_MemRead = 1'b1; EX_rt = 5'd3; ID_rs = 5'd3;
    for (int i = 0; i < 17; i++) clk_cycle();
    set_idle();
    #1;
    tests_run++;
    if (stall_cnt !== CW'(1)) begin
      tests_failed++;
      $display("FAIL stall_wrap got %0d expected 1", stall_cnt);
    end
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ID_rs        = 5'($urandom_range(0, 3));
      ID_rt        = 5'($urandom_range(0, 3));
      EX_rt        = 5'($urandom_range(0, 3));
      ID_usesRt    = ($urandom_range(0, 1) == 1);
      EX_MemRead   = ($urandom_range(0, 2) == 0);
      ID_isMulDiv  = ($urandom_range(0, 5) == 0);
      ID_readsHiLo = ($urandom_range(0, 3) == 0);
      EX_taken     = ($urandom_range(0, 6) == 0);
      mem_busy     = ($urandom_range(0, 5) == 0);
      #1;
      mode = model_mode();
      tests_run++;
      if (ctrl !== exp_ctrl(mode, m_md != 0)) begin
        tests_failed++;
        $display("FAIL rnd_ctrl[%0d] got %b expected %b", c, ctrl, exp_ctrl(mode, m_md != 0));
      end
      tests_run++;
      if ({stall_cnt, flush_cnt, freeze_cnt} !== exp_cnts()) begin
        tests_failed++;
        $display("FAIL rnd_cnts[%0d] got %h expected %h", c, {stall_cnt, flush_cnt, freeze_cnt}, exp_cnts());
      end
      clk_cycle();
    end
    set_idle();
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    test_reset();
    test_load_use();
    test_mul_interlock();
    test_flush_beats_stall();
    test_freeze();
    test_reset_mid_md();
    test_counter_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller. It generates the bubble (ID_EX_sel), hold, write-enable and flush controls consumed by the PC, IF_ID, ID_EX and EX_MEM registers. It covers four cases: load-use stalls, taken branch/jump flushes resolved in EX, multi-cycle MUL/DIV HI/LO interlocks, and full-pipeline freeze while data memory is busy. It also keeps performance counters for stall, flush and freeze cycles.

Parameters:
MD_LATENCY, 32, cycles from MUL/DIV issue until HI/LO is valid (1..255)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-high reset
ID_rs  in  5  rs field of the instruction in ID
ID_rt  in  5  rt field of the instruction in ID
ID_usesRt  in  1  ID instruction reads rt as a source
ID_isMulDiv  in  1  ID instruction is MULT/MULTU/DIV/DIVU
ID_readsHiLo  in  1  ID instruction is MFHI/MFLO
EX_MemRead  in  1  o_MemRead of ID_EX
EX_rt  in  5  o_rt of ID_EX (load destination)
EX_taken  in  1  branch taken or jump in EX; PC target mux is external
mem_busy  in  1  data memory not ready this cycle
PC_write  out  1  PC load enable
IF_ID_write  out  1  IF_ID load enable
IF_ID_flush  out  1  IF_ID clears to NOP at the next edge
ID_EX_sel  out  1  ID_EX loads a bubble at the next edge
ID_EX_hold  out  1  ID_EX keeps its contents
EX_MEM_hold  out  1  EX_MEM keeps its contents
md_busy  out  1  MUL/DIV result pending (md_cnt != 0)
stall_cnt  out  CNT_W  cycles with a stall bubble
flush_cnt  out  CNT_W  taken-flush cycles
freeze_cnt  out  CNT_W  mem_busy freeze cycles

Behaviour:
- Registered state: md_cnt[7:0] and the three counters. All control outputs are combinational from state and current inputs.
- FSM: MD_IDLE (md_cnt=0) and MD_BUSY (md_cnt>0).
  - MD_IDLE -> MD_BUSY when issue && ID_isMulDiv; md_cnt loads MD_LATENCY.
  - In MD_BUSY, md_cnt decrements every cycle, freeze cycles included.
  - MD_BUSY -> MD_IDLE when md_cnt reaches 0.
- lu_hazard = EX_MemRead && EX_rt!=0 && (EX_rt==ID_rs || (ID_usesRt && EX_rt==ID_rt)).
- md_hazard = md_busy && (ID_readsHiLo || ID_isMulDiv).
- Priority per cycle, highest first:
  1. rst high: PC_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_sel=1, holds=0. md_cnt, counters and md_busy are 0 asynchronously.
  2. mem_busy (freeze): PC_write=0, IF_ID_write=0, ID_EX_hold=1, EX_MEM_hold=1, ID_EX_sel=0, IF_ID_flush=0. EX_taken stays pending and is acted on in the first non-busy cycle. freeze_cnt increments.
  3. EX_taken (flush): PC_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_sel=1. Any lu/md hazard is ignored because the ID instruction is wrong-path. flush_cnt increments.
  4. lu_hazard || md_hazard (stall): PC_write=0, IF_ID_write=0, ID_EX_sel=1. stall_cnt increments.
  5. Otherwise (run): PC_write=1, IF_ID_write=1, other controls 0.
- issue = priority 5 active. A MUL/DIV stalled or flushed in ID does not load md_cnt.
- Load-use costs exactly one bubble; the load leaves EX the next cycle, clearing lu_hazard.
- md_hazard stall lasts until md_cnt=0. With MD_LATENCY=L and a dependent MFHI directly after MULT, there are L stall cycles.
- A MUL/DIV issuing while md_busy is impossible, since md_hazard stalls it.
- Counters wrap at 2^CNT_W. Exactly one of the freeze/flush/stall counters increments per cycle, or none.
- rst asserted mid-stall or mid-MD clears everything immediately. The first cycle after deassertion is a run cycle unless the inputs say otherwise.

Decomposition:
- Shared package holds the field widths and a hazard-cause encoding (NONE, FREEZE, FLUSH, LU, MD) used by this block and the trace/debug logic.
- One sub-module, hazard_perf_counter: a CNT_W counter with enable and async reset, instantiated three times.

Test Plan:
- Load-use: EX_MemRead=1, EX_rt=5, ID_rs=5 for one cycle -> that cycle PC_write=0, IF_ID_write=0, ID_EX_sel=1; next cycle run; stall_cnt=1. Repeat with EX_rt=0 -> no stall.
- MUL interlock: MD_LATENCY=4, MULT issues, then MFHI in ID next cycle -> md_busy high, 4 stall cycles, MFHI issues on the 5th; stall_cnt=4.
- Flush beats stall: EX_taken=1 together with lu_hazard -> IF_ID_flush=1, ID_EX_sel=1, PC_write=1; flush_cnt+1, stall_cnt unchanged.
- Freeze: mem_busy=1 for 3 cycles while EX_taken=1 -> holds asserted, PC_write=0, no flush for 3 cycles; flush on the 4th cycle; freeze_cnt=3; md_cnt keeps decrementing.
- Reset mid-MD: md_cnt=3, then assert rst asynchronously between edges -> md_busy=0 and counters=0 immediately; ID_EX_sel=1 while rst is high.
- Counter wrap: CNT_W=4, 17 stall cycles -> stall_cnt=1.
